// File: rtl/timing_trigger.sv
// timing_trigger: multi-channel armed trigger for the timing-attack capture path.
// While en is high the block is armed; qualifying channel activity is timestamped
// relative to the arm point and reported as one registered event per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         arm level (high = armed session)
//   din        monitored channel inputs, synchronous to clk
//   mode       0 = level reporting, 1 = one-shot rising-edge reporting (sampled at arm)
//   holdoff    minimum timestamp for qualification (sampled at arm)
//   valid      one-cycle event strobe
//   ch_id      channel index of the current event
//   timestamp  counter value at which the event was sampled
//   hit_mask   level: all qualified channels; edge: one-hot of ch_id
//   overflow   sticky, counter saturated this session
//   done       edge mode: every channel fired and was reported
//
// state | meaning
// IDLE  | disarmed, waiting for en
// ARMED | session running, counter advancing, events reported
module timing_trigger #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int ID_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] din,
  input  logic                mode,
  input  logic [CNT_W-1:0]    holdoff,
  output logic                valid,
  output logic [ID_W-1:0]     ch_id,
  output logic [CNT_W-1:0]    timestamp,
  output logic [CHANNELS-1:0] hit_mask,
  output logic                overflow,
  output logic                done
);

  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0]    holdoff_l, holdoff_l_nxt;
  logic                mode_l, mode_l_nxt;
  logic [CHANNELS-1:0] din_prev;
  logic [CHANNELS-1:0] fired, fired_nxt;
  logic [CHANNELS-1:0] pending, pending_nxt;
  logic [CNT_W-1:0]    ts_reg     [CHANNELS];
  logic [CNT_W-1:0]    ts_reg_nxt [CHANNELS];

  logic                valid_nxt;
  logic [ID_W-1:0]     ch_id_nxt;
  logic [CNT_W-1:0]    timestamp_nxt;
  logic [CHANNELS-1:0] hit_mask_nxt;
  logic                overflow_nxt;
  logic                done_nxt;

  logic                q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] hits;
  logic [CHANNELS-1:0] new_edges;
  logic [CHANNELS-1:0] avail;
  logic [ID_W-1:0]     sel_idx;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [CHANNELS-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    holdoff_l_nxt = holdoff_l;
    mode_l_nxt    = mode_l;
    fired_nxt     = fired;
    pending_nxt   = pending;
    ts_reg_nxt    = ts_reg;
    valid_nxt     = 1'b0;
    ch_id_nxt     = ch_id;
    timestamp_nxt = timestamp;
    hit_mask_nxt  = hit_mask;
    overflow_nxt  = overflow;
    done_nxt      = done;

    // Qualification uses the counter value before this edge's increment.
    rise      = din & ~din_prev;
    q         = (cnt >= holdoff_l);
    hits      = q ? din : '0;
    new_edges = q ? (rise & ~fired) : '0;
    // Edges captured on this very edge may be reported immediately.
    avail     = pending | new_edges;
    sel_idx   = lowest_idx(mode_l ? avail : hits);

    case (state)
      IDLE: begin
        if (en) begin
          state_nxt     = ARMED;
          cnt_nxt       = '0;
          mode_l_nxt    = mode;
          holdoff_l_nxt = holdoff;
          fired_nxt     = '0;
          pending_nxt   = '0;
          overflow_nxt  = 1'b0;
          done_nxt      = 1'b0;
        end
      end
      ARMED: begin
        if (!en) begin
          // Leaving the session: nothing is sampled and pending events are dropped.
          state_nxt = IDLE;
        end else begin
          if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_MAX) overflow_nxt = 1'b1;

          if (!mode_l) begin
            if (|hits) begin
              valid_nxt     = 1'b1;
              ch_id_nxt     = sel_idx;
              timestamp_nxt = cnt;
              hit_mask_nxt  = hits;
            end
          end else begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (new_edges[i]) ts_reg_nxt[i] = cnt;
            end
            fired_nxt   = fired | new_edges;
            pending_nxt = avail;
            if (|avail) begin
              valid_nxt            = 1'b1;
              ch_id_nxt            = sel_idx;
              timestamp_nxt        = ts_reg_nxt[sel_idx];
              hit_mask_nxt         = CHANNELS'(1) << sel_idx;
              pending_nxt[sel_idx] = 1'b0;
            end
            if ((&fired_nxt) && (pending_nxt == '0)) done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      holdoff_l <= '0;
      mode_l    <= 1'b0;
      din_prev  <= '0;
      fired     <= '0;
      pending   <= '0;
      for (int i = 0; i < CHANNELS; i++) ts_reg[i] <= '0;
      valid     <= 1'b0;
      ch_id     <= '0;
      timestamp <= '0;
      hit_mask  <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      holdoff_l <= holdoff_l_nxt;
      mode_l    <= mode_l_nxt;
      din_prev  <= din;
      fired     <= fired_nxt;
      pending   <= pending_nxt;
      for (int i = 0; i < CHANNELS; i++) ts_reg[i] <= ts_reg_nxt[i];
      valid     <= valid_nxt;
      ch_id     <= ch_id_nxt;
      timestamp <= timestamp_nxt;
      hit_mask  <= hit_mask_nxt;
      overflow  <= overflow_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: doc/timing_trigger.md
# timing_trigger

Multi-channel, parametrised trigger for the timing-attack capture path. While `en` is held high the block is armed. It timestamps qualifying activity on up to `CHANNELS` inputs relative to the arm point and emits one registered event per cycle on `valid`, with the channel index and timestamp. A holdoff window suppresses early activity. Two modes are supported: per-cycle level reporting, and one-shot rising-edge reporting with buffering of simultaneous edges.

## Interface
- `CHANNELS`, 4: number of `din` inputs, 1..16.
- `CNT_W`, 16: timestamp/holdoff width, ≥2.
- `ID_W`, `$clog2(CHANNELS)` (min 1): width of `ch_id`.

- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: arm level; high = armed session, low = idle.
- `din` in CHANNELS: monitored signals, synchronous to `clk`.
- `mode` in 1: 0 = level, 1 = first-edge one-shot; sampled at arm.
- `holdoff` in CNT_W: minimum timestamp for qualification; sampled at arm.
- `valid` out 1: one-cycle event strobe.
- `ch_id` out ID_W: channel of the current event.
- `timestamp` out CNT_W: counter value at which the event was sampled.
- `hit_mask` out CHANNELS: level mode: all qualified channels this event; edge mode: one-hot of `ch_id`.
- `overflow` out 1: sticky; counter saturated this session.
- `done` out 1: edge mode, every channel fired and reported.

## Operation
- States: IDLE, ARMED.
- IDLE → ARMED on an edge with `en`=1.
  - Actions: `cnt`←0, latch `mode`/`holdoff`, clear `fired`, `pending`, `overflow`, `done`.
- ARMED → IDLE on an edge with `en`=0.
  - Nothing is sampled on that edge; pending events are dropped.
- In ARMED with `en`=1, each edge does:
  - `cnt` ← `cnt`+1, saturating at all-ones.
  - When `cnt` reaches all-ones, `overflow`←1 and stays set.
  - Qualification, using the pre-increment `cnt`: `q` = (`cnt` ≥ `holdoff_l`).
- `din_prev` is registered every cycle in all states (reset 0); `rise` = `din` & ~`din_prev`.
- Level mode:
  - `hits` = `din` & {q}.
  - If `hits`≠0: `valid`←1, `ch_id`←lowest set index, `timestamp`←`cnt`, `hit_mask`←`hits`.
  - No buffering; repeats every cycle `din` stays high.
- Edge mode:
  - `new` = `rise` & {q} & ~`fired`.
  - Per-channel `ts_reg[i]`←`cnt` for each bit of `new`.
  - `fired`|=`new`, `pending`|=`new`.
  - Each cycle, if `pending`≠0 (including bits set this edge), report the lowest index `k`: `valid`←1, `ch_id`←k, `timestamp`←`ts_reg[k]` (or `cnt` if set this edge), `hit_mask`←1<<k, clear `pending[k]`.
  - A channel reports at most once per session.
  - `done`←1 once `fired` is all-ones and `pending`=0.
- `din` already high at arm produces no edge-mode event until it falls and rises again.
- Holdoff=0: first sample after arm qualifies. Holdoff all-ones: only qualifies after saturation.
- After saturation, events still report `timestamp` = all-ones.

## Timing
- Reset values: `valid`=0, `ch_id`=0, `timestamp`=0, `hit_mask`=0, `overflow`=0, `done`=0; state IDLE; `cnt`, `fired`, `pending`, `din_prev`, `ts_reg` all 0.
- Arm edge t0. First qualifying sample is at t0+1 with `cnt`=0.
- Latency: `din` sampled at edge t → `valid` high in the cycle after t. One cycle, registered.
- `valid` is low in every cycle without an event; back-to-back events are allowed.
- Edge mode, m simultaneous edges: reported on m consecutive cycles, ascending index. Their timestamps are all equal.
- `en` low at edge t: `valid` is 0 after t, even with pending bits.
- Re-arm (`en` high again): pending and fired are cleared; a fresh session starts.
- Outputs other than `valid` hold their last values while `valid`=0.
- Async reset mid-session: immediate return to the reset values above.

## Test plan
- Level, CHANNELS=4, holdoff=0: arm, then `din`=4'b0010 for 3 cycles starting at the 6th post-arm sample → `valid` 3 cycles, `ch_id`=1, `timestamp`=5,6,7.
- Holdoff=10, edge mode: rise on ch0 at `cnt`=4, then rise on ch0 at `cnt`=12 → single event `ch_id`=0, `timestamp`=12.
- Edge mode: rises on ch0, ch2, ch3 at the same edge with `cnt`=7 → 3 consecutive `valid` cycles, `ch_id`=0,2,3, all `timestamp`=7. Then rises on ch1 → ch1 event and `done`=1 the cycle after.
- CNT_W=4: stay armed 20 cycles, rise at `cnt` saturation → `overflow`=1, `timestamp`=15. Re-arm → `overflow`=0.
- Edge mode: 3 pending edges, `en` drops the next edge → at most one `valid` (from the edge before `en` low), none afterwards.
- Assert `rst_n` low mid-burst → all outputs 0 immediately. Release → IDLE, no event until re-armed.
